// File: rtl/piso_shifter.sv
// Parallel-in/serial-out shifter with a one-word holding buffer, programmable bit period and sticky underrun.
// Optional PISO_SHIFTER_RECIRC_EN adds a recirc input that replays the last loaded word instead of going idle.
module piso_shifter #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned DIV       = 1,
    parameter bit          LSB_FIRST = 1'b0,
    parameter bit          FILL      = 1'b0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             q,
    output logic             n_q,
    output logic             word_start,
    output logic             busy,
    output logic             underrun,
`ifdef PISO_SHIFTER_RECIRC_EN
    input  logic             recirc,
`endif
    input  logic             underrun_clr
);

    localparam int unsigned BIT_W = $clog2(WIDTH);
    localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(WIDTH - 1);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [WIDTH-1:0] FILL_WORD = {WIDTH{FILL}};

    typedef enum logic {
        S_IDLE,
        S_SHIFT
    } state_t;

    state_t           state_q,      state_d;
    logic [WIDTH-1:0] shreg_q,      shreg_d;
    logic [WIDTH-1:0] hold_q,       hold_d;
    logic             hold_valid_q, hold_valid_d;
    logic [BIT_W-1:0] bit_cnt_q,    bit_cnt_d;
    logic [DIV_W-1:0] div_cnt_q,    div_cnt_d;
    logic             in_ready_q,   in_ready_d;
    logic             q_q,          q_d;
    logic             n_q_q,        n_q_d;
    logic             word_start_q, word_start_d;
    logic             busy_q,       busy_d;
    logic             underrun_q,   underrun_d;
`ifdef PISO_SHIFTER_RECIRC_EN
    logic [WIDTH-1:0] last_q,       last_d;
`endif

    logic load_hold;
    logic underrun_set;

    function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] v);
        if (LSB_FIRST) return {FILL, v[WIDTH-1:1]};
        else           return {v[WIDTH-2:0], FILL};
    endfunction

    function automatic logic out_bit(input logic [WIDTH-1:0] v);
        return LSB_FIRST ? v[0] : v[WIDTH-1];
    endfunction

    always_comb begin
        // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latches).
        state_d      = state_q;
        shreg_d      = shreg_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        bit_cnt_d    = bit_cnt_q;
        div_cnt_d    = div_cnt_q;
        load_hold    = 1'b0;
        underrun_set = 1'b0;
`ifdef PISO_SHIFTER_RECIRC_EN
        last_d       = last_q;
`endif

        // Buffer accepts only while empty, so it never collides with a load that empties it.
        if (in_valid && in_ready_q) begin
            hold_d       = in_data;
            hold_valid_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (hold_valid_q) load_hold = 1'b1;
            end
            S_SHIFT: begin
                if (shift_en) begin
                    if (div_cnt_q == DIV_LAST) begin
                        div_cnt_d = '0;
                        if (bit_cnt_q == LAST_BIT) begin
                            if (hold_valid_q) begin
                                load_hold = 1'b1;
`ifdef PISO_SHIFTER_RECIRC_EN
                            end else if (recirc) begin
                                shreg_d   = last_q;
                                bit_cnt_d = '0;
`endif
                            end else begin
                                state_d      = S_IDLE;
                                shreg_d      = FILL_WORD;
                                bit_cnt_d    = '0;
                                underrun_set = 1'b1;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                            shreg_d   = shift_once(shreg_q);
                        end
                    end else begin
                        div_cnt_d = div_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (load_hold) begin
            state_d      = S_SHIFT;
            shreg_d      = hold_q;
            hold_valid_d = 1'b0;
            bit_cnt_d    = '0;
            div_cnt_d    = '0;
`ifdef PISO_SHIFTER_RECIRC_EN
            last_d       = hold_q;
`endif
        end

        word_start_d = load_hold;
`ifdef PISO_SHIFTER_RECIRC_EN
        word_start_d = load_hold || (state_q == S_SHIFT && shift_en && div_cnt_q == DIV_LAST &&
                                     bit_cnt_q == LAST_BIT && !hold_valid_q && recirc);
`endif
        // Set wins over a simultaneous clear.
        underrun_d = underrun_set || (underrun_q && !underrun_clr);
        in_ready_d = !hold_valid_d;
        q_d        = out_bit(shreg_d);
        n_q_d      = !q_d;
        busy_d     = (state_d == S_SHIFT);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (clr) begin
            state_q      <= S_IDLE;
            shreg_q      <= FILL_WORD;
            hold_q       <= FILL_WORD;
            hold_valid_q <= 1'b0;
            bit_cnt_q    <= '0;
            div_cnt_q    <= '0;
            in_ready_q   <= 1'b1;
            q_q          <= FILL;
            n_q_q        <= !FILL;
            word_start_q <= 1'b0;
            busy_q       <= 1'b0;
            underrun_q   <= 1'b0;
`ifdef PISO_SHIFTER_RECIRC_EN
            last_q       <= FILL_WORD;
`endif
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            bit_cnt_q    <= bit_cnt_d;
            div_cnt_q    <= div_cnt_d;
            in_ready_q   <= in_ready_d;
            q_q          <= q_d;
            n_q_q        <= n_q_d;
            word_start_q <= word_start_d;
            busy_q       <= busy_d;
            underrun_q   <= underrun_d;
`ifdef PISO_SHIFTER_RECIRC_EN
            last_q       <= last_d;
`endif
        end
    end

    assign in_ready   = in_ready_q;
    assign q          = q_q;
    assign n_q        = n_q_q;
    assign word_start = word_start_q;
    assign busy       = busy_q;
    assign underrun   = underrun_q;

    a_busy_state: assert property (@(posedge clk) disable iff (clr) busy_q == (state_q == S_SHIFT));
    a_ready_hold: assert property (@(posedge clk) disable iff (clr) in_ready_q == !hold_valid_q);
    a_bit_range:  assert property (@(posedge clk) disable iff (clr) bit_cnt_q <= LAST_BIT);
    a_div_range:  assert property (@(posedge clk) disable iff (clr) div_cnt_q <= DIV_LAST);
    a_ws_busy:    assert property (@(posedge clk) disable iff (clr) word_start_q |-> busy_q);

endmodule

// File: tb/tb_piso_shifter.sv
// Scoreboard bench for piso_shifter: dut0 is 8-bit MSB-first DIV=1, dut1 is 8-bit LSB-first DIV=3.
`timescale 1ns/1ps
module tb_piso_shifter;

    typedef struct packed {
        logic q;
        logic ws;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       clr;
    logic       d0_en, d0_valid, d0_ready, d0_q, d0_nq, d0_ws, d0_busy, d0_ur, d0_urclr;
    logic [7:0] d0_data;
    logic       d1_en, d1_valid, d1_ready, d1_q, d1_nq, d1_ws, d1_busy, d1_ur, d1_urclr;
    logic [7:0] d1_data;
`ifdef PISO_SHIFTER_RECIRC_EN
    logic       d0_recirc, d1_recirc;
`endif

    int   checks = 0;
    int   errors = 0;
    exp_t sb0[$];
    exp_t sb1[$];

    piso_shifter #(.WIDTH(8), .DIV(1), .LSB_FIRST(1'b0), .FILL(1'b0)) dut0 (
        .clk(clk), .clr(clr), .shift_en(d0_en), .in_data(d0_data), .in_valid(d0_valid),
        .in_ready(d0_ready), .q(d0_q), .n_q(d0_nq), .word_start(d0_ws), .busy(d0_busy),
        .underrun(d0_ur),
`ifdef PISO_SHIFTER_RECIRC_EN
        .recirc(d0_recirc),
`endif
        .underrun_clr(d0_urclr)
    );

    piso_shifter #(.WIDTH(8), .DIV(3), .LSB_FIRST(1'b1), .FILL(1'b0)) dut1 (
        .clk(clk), .clr(clr), .shift_en(d1_en), .in_data(d1_data), .in_valid(d1_valid),
        .in_ready(d1_ready), .q(d1_q), .n_q(d1_nq), .word_start(d1_ws), .busy(d1_busy),
        .underrun(d1_ur),
`ifdef PISO_SHIFTER_RECIRC_EN
        .recirc(d1_recirc),
`endif
        .underrun_clr(d1_urclr)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected bits are given in transmission order, one entry per busy cycle of dut0.
    task automatic push0(input logic [7:0] bits);
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            e.q  = bits[7-i];
            e.ws = (i == 0);
            sb0.push_back(e);
        end
    endtask

    task automatic send0(input logic [7:0] w);
        int n;
        @(negedge clk);
        d0_data  = w;
        d0_valid = 1'b1;
        n = 0;
        while (!d0_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("d0_send_accept", d0_ready, 1'b1);
        @(negedge clk);
        d0_valid = 1'b0;
    endtask

    task automatic send1(input logic [7:0] w);
        int n;
        @(negedge clk);
        d1_data  = w;
        d1_valid = 1'b1;
        n = 0;
        while (!d1_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("d1_send_accept", d1_ready, 1'b1);
        @(negedge clk);
        d1_valid = 1'b0;
    endtask

    exp_t m0;
    always @(negedge clk) begin
        if (d0_busy === 1'b1) begin
            if (sb0.size() == 0) begin
                check("d0_unexpected_busy", d0_busy, 1'b0);
            end else begin
                m0 = sb0.pop_front();
                check("d0_q", d0_q, m0.q);
                check("d0_nq", d0_nq, !m0.q);
                check("d0_word_start", d0_ws, m0.ws);
            end
        end else if (clr === 1'b0 && d0_ws !== 1'b0) begin
            check("d0_ws_while_idle", d0_ws, 1'b0);
        end
    end

    exp_t m1;
    always @(negedge clk) begin
        if (d1_busy === 1'b1) begin
            if (sb1.size() == 0) begin
                check("d1_unexpected_busy", d1_busy, 1'b0);
            end else begin
                m1 = sb1.pop_front();
                check("d1_q", d1_q, m1.q);
                check("d1_nq", d1_nq, !m1.q);
                check("d1_word_start", d1_ws, m1.ws);
            end
        end else if (clr === 1'b0 && d1_ws !== 1'b0) begin
            check("d1_ws_while_idle", d1_ws, 1'b0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int seen;
        exp_t e;
        clr = 1'b1;
        d0_en = 1'b1; d0_valid = 1'b0; d0_data = '0; d0_urclr = 1'b0;
        d1_en = 1'b1; d1_valid = 1'b0; d1_data = '0; d1_urclr = 1'b0;
`ifdef PISO_SHIFTER_RECIRC_EN
        d0_recirc = 1'b0; d1_recirc = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("rst_q", d0_q, 1'b0);
        check("rst_nq", d0_nq, 1'b1);
        check("rst_in_ready", d0_ready, 1'b1);
        check("rst_busy", d0_busy, 1'b0);
        check("rst_underrun", d0_ur, 1'b0);
        check("rst_word_start", d0_ws, 1'b0);
        clr = 1'b0;

        // Single word 0xA5; send0 returns one cycle after the handshake cycle.
        push0(8'b1010_0101);
        send0(8'hA5);
        check("t1_in_ready_full", d0_ready, 1'b0);
        n = 0;
        while (!d0_ws && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t1_ws_latency", n, 1);
        check("t1_in_ready_back", d0_ready, 1'b1);
        repeat (8) @(negedge clk);
        check("t1_idle_busy", d0_busy, 1'b0);
        check("t1_idle_q", d0_q, 1'b0);
        check("t1_idle_nq", d0_nq, 1'b1);
        check("t1_underrun", d0_ur, 1'b1);

        d0_urclr = 1'b1;
        @(negedge clk);
        d0_urclr = 1'b0;
        check("t5_underrun_cleared", d0_ur, 1'b0);

        // Back-to-back 0xFF then 0x00, with a clear landing on the underrun edge.
        push0(8'b1111_1111);
        push0(8'b0000_0000);
        send0(8'hFF);
        send0(8'h00);
        repeat (14) @(negedge clk);
        check("t2_last_bit_busy", d0_busy, 1'b1);
        check("t2_no_underrun_yet", d0_ur, 1'b0);
        d0_urclr = 1'b1;
        @(negedge clk);
        d0_urclr = 1'b0;
        check("t2_end_busy", d0_busy, 1'b0);
        check("t5_set_beats_clear", d0_ur, 1'b1);
        check("t2_end_q", d0_q, 1'b0);

        // Reset mid-word (bit 4 of 0xF0) with the buffer holding 0xAA.
        push0(8'b1111_0000);
        send0(8'hF0);
        send0(8'hAA);
        check("t4_hold_full", d0_ready, 1'b0);
        repeat (3) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        sb0.delete();
        check("t4_q", d0_q, 1'b0);
        check("t4_nq", d0_nq, 1'b1);
        check("t4_busy", d0_busy, 1'b0);
        check("t4_in_ready", d0_ready, 1'b1);
        check("t4_underrun", d0_ur, 1'b0);
        check("t4_word_start", d0_ws, 1'b0);
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (d0_ws || d0_busy) seen++;
        end
        check("t4_quiet_after_reset", seen, 0);

        // DIV=3, LSB first, shift_en toggling: bit 0 held 6 clocks, 48 busy clocks total.
        for (int i = 0; i < 48; i++) begin
            e.q  = (i < 6);
            e.ws = (i == 0);
            sb1.push_back(e);
        end
        send1(8'h01);
        for (int k = 1; k <= 48; k++) begin
            d1_en = k[0];
            @(negedge clk);
        end
        check("t3_last_cycle_busy", d1_busy, 1'b1);
        check("t3_no_underrun_yet", d1_ur, 1'b0);
        d1_en = 1'b1;
        @(negedge clk);
        check("t3_end_busy", d1_busy, 1'b0);
        check("t3_underrun", d1_ur, 1'b1);
        check("t3_end_q", d1_q, 1'b0);

`ifdef PISO_SHIFTER_RECIRC_EN
        // Recirculate 0x3C for three words, then drop recirc during the third.
        push0(8'b0011_1100);
        push0(8'b0011_1100);
        push0(8'b0011_1100);
        d0_recirc = 1'b1;
        send0(8'h3C);
        repeat (19) @(negedge clk);
        check("t6_recirc_no_underrun", d0_ur, 1'b0);
        d0_recirc = 1'b0;
        repeat (5) @(negedge clk);
        check("t6_last_cycle_busy", d0_busy, 1'b1);
        check("t6_still_no_underrun", d0_ur, 1'b0);
        @(negedge clk);
        check("t6_end_busy", d0_busy, 1'b0);
        check("t6_underrun", d0_ur, 1'b1);
`endif

        repeat (2) @(negedge clk);
        check("sb0_drained", sb0.size(), 0);
        check("sb1_drained", sb1.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
